// File: rtl/fft_pkg.sv
// Shared FFT definitions: ROM phase encodings, default word widths and the complex-sample type.
package fft_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int FRAC_DEF   = 8;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_BFLY = 2'd1,
        ST_TWID = 2'd2,
        ST_RSVD = 2'd3
    } state_e;

    typedef struct packed {
        logic signed [DATA_W_DEF-1:0] re;
        logic signed [DATA_W_DEF-1:0] im;
    } cplx_t;

endpackage

// File: rtl/sdf_r2_butterfly_stage_if.sv
// Sample/twiddle bus between the twiddle ROM side and an SDF butterfly stage.
interface sdf_r2_butterfly_stage_if #(
    parameter int DATA_W = fft_pkg::DATA_W_DEF
);
    logic              in_valid;
    logic [DATA_W-1:0] din_r;
    logic [DATA_W-1:0] din_i;
    logic [1:0]        state;
    logic [DATA_W-1:0] w_r;
    logic [DATA_W-1:0] w_i;
    logic              out_valid;
    logic [DATA_W-1:0] dout_r;
    logic [DATA_W-1:0] dout_i;

    modport master (
        output in_valid, din_r, din_i, state, w_r, w_i,
        input  out_valid, dout_r, dout_i
    );

    modport slave (
        input  in_valid, din_r, din_i, state, w_r, w_i,
        output out_valid, dout_r, dout_i
    );
endinterface

// File: rtl/sdf_delay_line.sv
// DELAY-deep complex shift register: push enters tap 0, head is the oldest tap.
module sdf_delay_line #(
    parameter int DATA_W = 24,
    parameter int DELAY  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_push_r,
    input  logic [DATA_W-1:0] i_push_i,
    output logic [DATA_W-1:0] o_head_r,
    output logic [DATA_W-1:0] o_head_i
);
    genvar gi;
    generate
        for (gi = 0; gi < DELAY; gi++) begin : g_tap
            logic [DATA_W-1:0] r_tap_r;
            logic [DATA_W-1:0] r_tap_i;
            logic [DATA_W-1:0] w_src_r;
            logic [DATA_W-1:0] w_src_i;

            if (gi == 0) begin : g_first
                assign w_src_r = i_push_r;
                assign w_src_i = i_push_i;
            end else begin : g_next
                assign w_src_r = g_tap[gi-1].r_tap_r;
                assign w_src_i = g_tap[gi-1].r_tap_i;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_tap_r <= '0;
                    r_tap_i <= '0;
                end else if (i_en) begin
                    r_tap_r <= w_src_r;
                    r_tap_i <= w_src_i;
                end
            end
        end
    endgenerate

    assign o_head_r = g_tap[DELAY-1].r_tap_r;
    assign o_head_i = g_tap[DELAY-1].r_tap_i;
endmodule

// File: rtl/sdf_r2_butterfly_stage.sv
// Radix-2 SDF DIF butterfly stage driven by the paired twiddle ROM's phase and twiddle.
// Define SDF_ROUND_EN to round (half up) the twiddle products instead of flooring them.
module sdf_r2_butterfly_stage
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DELAY  = 4,
    parameter int FRAC   = FRAC_DEF
) (
    input logic clk,
    input logic rst_n,
    sdf_r2_butterfly_stage_if.slave bus
);
    localparam int PW = 2*DATA_W + 1;
`ifdef SDF_ROUND_EN
    localparam logic signed [PW-1:0] RND = PW'(1) <<< (FRAC-1);
`else
    localparam logic signed [PW-1:0] RND = '0;
`endif

    state_e            w_state;
    logic [DATA_W-1:0] w_head_r, w_head_i;
    logic [DATA_W-1:0] w_push_r, w_push_i;
    logic [DATA_W-1:0] w_sum_r, w_sum_i, w_diff_r, w_diff_i;
    logic signed [PW-1:0] w_hr_x, w_hi_x, w_wr_x, w_wi_x;
    logic signed [PW-1:0] w_prod_re, w_prod_im;
    logic [DATA_W-1:0] w_twid_r, w_twid_i;
    logic              w_unused_bits;
    logic              r_valid;
    logic [DATA_W-1:0] r_dout_r, r_dout_i;

    assign w_state = state_e'(bus.state);

    // Wrap-around add/sub at DATA_W: no growth, no saturation.
    assign w_sum_r  = w_head_r + bus.din_r;
    assign w_sum_i  = w_head_i + bus.din_i;
    assign w_diff_r = w_head_r - bus.din_r;
    assign w_diff_i = w_head_i - bus.din_i;

    assign w_push_r = (w_state == ST_BFLY) ? w_diff_r : bus.din_r;
    assign w_push_i = (w_state == ST_BFLY) ? w_diff_i : bus.din_i;

    sdf_delay_line #(
        .DATA_W (DATA_W),
        .DELAY  (DELAY)
    ) u_delay (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_en     (bus.in_valid),
        .i_push_r (w_push_r),
        .i_push_i (w_push_i),
        .o_head_r (w_head_r),
        .o_head_i (w_head_i)
    );

    // Operands are sign-extended to the full product width so nothing is lost before the shift.
    assign w_hr_x = PW'($signed(w_head_r));
    assign w_hi_x = PW'($signed(w_head_i));
    assign w_wr_x = PW'($signed(bus.w_r));
    assign w_wi_x = PW'($signed(bus.w_i));

    assign w_prod_re = w_hr_x * w_wr_x - w_hi_x * w_wi_x + RND;
    assign w_prod_im = w_hr_x * w_wi_x + w_hi_x * w_wr_x + RND;

    // Arithmetic shift by FRAC then keep DATA_W bits == this bit slice.
    assign w_twid_r = w_prod_re[FRAC +: DATA_W];
    assign w_twid_i = w_prod_im[FRAC +: DATA_W];
    assign w_unused_bits = ^{w_prod_re[FRAC-1:0], w_prod_re[PW-1:FRAC+DATA_W],
                             w_prod_im[FRAC-1:0], w_prod_im[PW-1:FRAC+DATA_W]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= 1'b0;
            r_dout_r <= '0;
            r_dout_i <= '0;
        end else begin
            r_valid <= 1'b0;
            if (bus.in_valid) begin
                case (w_state)
                    ST_BFLY: begin
                        r_valid  <= 1'b1;
                        r_dout_r <= w_sum_r;
                        r_dout_i <= w_sum_i;
                    end
                    ST_TWID: begin
                        r_valid  <= 1'b1;
                        r_dout_r <= w_twid_r;
                        r_dout_i <= w_twid_i;
                    end
                    default: r_valid <= 1'b0;
                endcase
            end
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.dout_r    = r_dout_r;
    assign bus.dout_i    = r_dout_i;
endmodule

// File: tb/tb_sdf_r2_butterfly_stage.sv
// Directed-vector bench for sdf_r2_butterfly_stage (DELAY=4, DATA_W=24, FRAC=8).
module tb_sdf_r2_butterfly_stage;
    import fft_pkg::*;

    localparam int DW = 24;
`ifdef SDF_ROUND_EN
    localparam int  RR_RE = 1;
    localparam longint RND_M = 128;
`else
    localparam int  RR_RE = 0;
    localparam longint RND_M = 0;
`endif

    typedef struct {
        logic       iv;
        logic [1:0] st;
        int         xr, xi, wr, wi;
        logic       ev;
        int         er, ei;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    vec_t vt[$];
    int   tw_r[4] = '{256, 181, 0, -181};
    int   tw_i[4] = '{0, -181, -256, -181};

    sdf_r2_butterfly_stage_if #(.DATA_W(DW)) bif ();

    sdf_r2_butterfly_stage #(.DATA_W(DW), .DELAY(4), .FRAC(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%h) want %0d (0x%h)", nm, $signed(act), act, $signed(exp), exp);
        end
    endtask

    task automatic apply(input logic iv, input logic [1:0] st, input int xr, input int xi,
                         input int wr, input int wi);
        bif.in_valid = iv;
        bif.state    = st;
        bif.din_r    = DW'(xr);
        bif.din_i    = DW'(xi);
        bif.w_r      = DW'(wr);
        bif.w_i      = DW'(wi);
        @(posedge clk);
        #1;
        $display("txn iv=%0b st=%0d x=(%0d,%0d) w=(%0d,%0d) -> ov=%0b dout=(%0d,%0d)",
                 iv, st, xr, xi, wr, wi, bif.out_valid, $signed(bif.dout_r), $signed(bif.dout_i));
    endtask

    task automatic add(input logic iv, input logic [1:0] st, input int xr, input int xi,
                       input int wr, input int wi, input logic ev, input int er, input int ei);
        vec_t v;
        v.iv = iv; v.st = st; v.xr = xr; v.xi = xi; v.wr = wr; v.wi = wi;
        v.ev = ev; v.er = er; v.ei = ei;
        vt.push_back(v);
    endtask

    function automatic logic [DW-1:0] twid(input longint dr, input longint di, input longint wr,
                                           input longint wi, input bit im);
        longint p;
        p = im ? (dr*wi + di*wr) : (dr*wr - di*wi);
        p = (p + RND_M) >>> 8;
        return DW'(p);
    endfunction

    initial begin
        int a_r[3][8];
        int a_i[3][8];
        int xr, xi;

        // Reset held with in_valid asserted: nothing must come out.
        bif.in_valid = 1'b1; bif.state = 2'd1; bif.din_r = 24'd5; bif.din_i = 24'd7;
        bif.w_r = 24'd256; bif.w_i = 24'd0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst_valid", {23'b0, bif.out_valid}, 24'd0);
            chk("rst_dout_r", bif.dout_r, 24'd0);
            chk("rst_dout_i", bif.dout_i, 24'd0);
        end
        rst_n = 1'b1;

        // Main frame: x[n] = n*256, zero input during twiddle phase.
        for (int n = 0; n < 4; n++) add(1, ST_FILL, n*256, 0, 0, 0, 0, 0, 0);
        add(1, ST_BFLY, 1024, 0, 0, 0, 1, 1024, 0);
        add(1, ST_BFLY, 1280, 0, 0, 0, 1, 1536, 0);
        add(1, ST_BFLY, 1536, 0, 0, 0, 1, 2048, 0);
        add(1, ST_BFLY, 1792, 0, 0, 0, 1, 2560, 0);
        add(1, ST_TWID, 0, 0, 256, 0, 1, -1024, 0);
        add(1, ST_TWID, 0, 0, 181, -181, 1, -724, 724);
        add(1, ST_TWID, 0, 0, 0, -256, 1, 0, 1024);
        add(1, ST_TWID, 0, 0, -181, -181, 1, 724, 724);

        // Same frame with a 3-cycle in_valid gap mid-butterfly.
        for (int n = 0; n < 4; n++) add(1, ST_FILL, n*256, 0, 0, 0, 0, 724, 724);
        add(1, ST_BFLY, 1024, 0, 0, 0, 1, 1024, 0);
        add(1, ST_BFLY, 1280, 0, 0, 0, 1, 1536, 0);
        for (int g = 0; g < 3; g++) add(0, ST_BFLY, 999, -999, 7, 7, 0, 1536, 0);
        add(1, ST_BFLY, 1536, 0, 0, 0, 1, 2048, 0);
        add(1, ST_BFLY, 1792, 0, 0, 0, 1, 2560, 0);
        add(1, ST_TWID, 0, 0, 256, 0, 1, -1024, 0);
        add(1, ST_TWID, 0, 0, 181, -181, 1, -724, 724);
        add(1, ST_TWID, 0, 0, 0, -256, 1, 0, 1024);
        add(1, ST_TWID, 0, 0, -181, -181, 1, 724, 724);

        // Overflow wrap and twiddle rounding; state 3 acts as fill.
        add(1, ST_FILL, 8388607, 0, 0, 0, 0, 724, 724);
        add(1, ST_RSVD, 1, 0, 0, 0, 0, 724, 724);
        add(1, ST_FILL, 0, 0, 0, 0, 0, 724, 724);
        add(1, ST_FILL, 0, 0, 0, 0, 0, 724, 724);
        add(1, ST_BFLY, 1, 0, 0, 0, 1, 8388608, 0);
        add(1, ST_BFLY, 0, 0, 0, 0, 1, 1, 0);
        add(1, ST_BFLY, 0, 0, 0, 0, 1, 0, 0);
        add(1, ST_BFLY, 0, 0, 0, 0, 1, 0, 0);
        add(1, ST_TWID, 0, 0, 256, 0, 1, 8388606, 0);
        add(1, ST_TWID, 0, 0, 181, -181, 1, RR_RE, -1);
        add(1, ST_TWID, 0, 0, 256, 0, 1, 0, 0);
        add(1, ST_TWID, 0, 0, 256, 0, 1, 0, 0);

        foreach (vt[i]) begin
            apply(vt[i].iv, vt[i].st, vt[i].xr, vt[i].xi, vt[i].wr, vt[i].wi);
            chk($sformatf("vec%0d_valid", i), {23'b0, bif.out_valid}, {23'b0, vt[i].ev});
            chk($sformatf("vec%0d_dout_r", i), bif.dout_r, DW'(vt[i].er));
            chk($sformatf("vec%0d_dout_i", i), bif.dout_i, DW'(vt[i].ei));
        end

        // Three back-to-back frames against a per-frame DIF butterfly model.
        for (int f = 0; f < 3; f++)
            for (int n = 0; n < 8; n++) begin
                a_r[f][n] = (f+1)*300 - n*97 + (n%3)*41;
                a_i[f][n] = n*53 - f*120 - 100;
            end
        for (int n = 0; n < 4; n++) begin
            apply(1, ST_FILL, a_r[0][n], a_i[0][n], 0, 0);
            chk("cont_fill_valid", {23'b0, bif.out_valid}, 24'd0);
        end
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 4; k++) begin
                apply(1, ST_BFLY, a_r[f][k+4], a_i[f][k+4], 0, 0);
                chk($sformatf("cont_f%0d_sum%0d_valid", f, k), {23'b0, bif.out_valid}, 24'd1);
                chk($sformatf("cont_f%0d_sum%0d_r", f, k), bif.dout_r, DW'(a_r[f][k] + a_r[f][k+4]));
                chk($sformatf("cont_f%0d_sum%0d_i", f, k), bif.dout_i, DW'(a_i[f][k] + a_i[f][k+4]));
            end
            for (int k = 0; k < 4; k++) begin
                xr = (f < 2) ? a_r[f+1][k] : 0;
                xi = (f < 2) ? a_i[f+1][k] : 0;
                apply(1, ST_TWID, xr, xi, tw_r[k], tw_i[k]);
                chk($sformatf("cont_f%0d_tw%0d_valid", f, k), {23'b0, bif.out_valid}, 24'd1);
                chk($sformatf("cont_f%0d_tw%0d_r", f, k), bif.dout_r,
                    twid(a_r[f][k] - a_r[f][k+4], a_i[f][k] - a_i[f][k+4], tw_r[k], tw_i[k], 1'b0));
                chk($sformatf("cont_f%0d_tw%0d_i", f, k), bif.dout_i,
                    twid(a_r[f][k] - a_r[f][k+4], a_i[f][k] - a_i[f][k+4], tw_r[k], tw_i[k], 1'b1));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
